// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types for the KSA, PRGA and key generator blocks
package rc4_pkg;

  localparam int RC4_BYTE_W        = 8;
  localparam int RC4_MAX_KEY_BYTES = 3;

  typedef logic [RC4_BYTE_W-1:0] rc4_byte_t;
  typedef rc4_byte_t [RC4_MAX_KEY_BYTES-1:0] rc4_key_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD_I,
    ST_WAIT_I,
    ST_RD_J,
    ST_WAIT_J,
    ST_WR_I,
    ST_WR_J,
    ST_FIN
  } ksa_state_t;

endpackage

// File: rtl/ram_wait_counter.sv
// rtl/ram_wait_counter.sv - down-counter covering the S-RAM read latency
module ram_wait_counter #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic expired
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CW-1:0] cnt;

  // Load on the read-issue cycle, then count the remaining wait cycles down to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(LATENCY - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - RC4 key-scheduling engine driving an external single-port S-RAM
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int ADDR_WIDTH    = RC4_BYTE_W,
  parameter int MAX_KEY_BYTES = 3,
  parameter int RAM_LATENCY   = 1,
  parameter bit DO_INIT       = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [$clog2(MAX_KEY_BYTES+1)-1:0]   key_len,
  input  logic [MAX_KEY_BYTES*ADDR_WIDTH-1:0]  key,
  output logic                                 busy,
  output logic                                 done,
  output logic [ADDR_WIDTH-1:0]                ram_addr,
  output logic [ADDR_WIDTH-1:0]                ram_wdata,
  output logic                                 ram_we,
  input  logic [ADDR_WIDTH-1:0]                ram_rdata
);

  localparam int KLW = $clog2(MAX_KEY_BYTES + 1);
  localparam int KW  = (MAX_KEY_BYTES > 1) ? $clog2(MAX_KEY_BYTES) : 1;
  localparam logic [KLW-1:0]        MAX_LEN  = KLW'(MAX_KEY_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  ksa_state_t                         state;
  logic [ADDR_WIDTH-1:0]              i;
  logic [ADDR_WIDTH-1:0]              j;
  logic [ADDR_WIDTH-1:0]              si;
  logic [KW-1:0]                      k;
  logic [KW-1:0]                      k_last;
  logic [MAX_KEY_BYTES*ADDR_WIDTH-1:0] key_r;

  logic                  accept;
  logic                  wait_load;
  logic                  wait_expired;
  logic [KLW-1:0]        len_eff;
  logic [ADDR_WIDTH-1:0] key_byte;
  logic [ADDR_WIDTH-1:0] j_next;
  logic [ADDR_WIDTH-1:0] i_inc;

  // A start in FIN is accepted too: busy is already low there
  assign accept    = start && ((state == ST_IDLE) || (state == ST_FIN));
  assign wait_load = (state == ST_RD_I) || (state == ST_RD_J);
  assign key_byte  = key_r[k*ADDR_WIDTH +: ADDR_WIDTH];
  assign j_next    = j + ram_rdata + key_byte;
  assign i_inc     = i + ADDR_WIDTH'(1);

  // Zero-length keys behave as one byte, oversized lengths clamp to the key port width
  always_comb begin
    len_eff = key_len;
    if (key_len == '0) begin
      len_eff = KLW'(1);
    end else if (key_len > MAX_LEN) begin
      len_eff = MAX_LEN;
    end
  end

  ram_wait_counter #(
    .LATENCY (RAM_LATENCY)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (wait_load),
    .expired (wait_expired)
  );

  // KSA sequencer; every RAM-facing output is set on entry to the state that uses it.
  // ram_wdata also serves as the sj latch between WAIT_J and WR_I.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      k         <= '0;
      k_last    <= '0;
      key_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
    end else begin
      done   <= 1'b0;
      ram_we <= 1'b0;
      if (accept) begin
        key_r     <= key;
        k_last    <= KW'(len_eff - KLW'(1));
        i         <= '0;
        j         <= '0;
        k         <= '0;
        busy      <= 1'b1;
        ram_addr  <= '0;
        ram_wdata <= '0;
        if (DO_INIT) begin
          state  <= ST_FILL;
          ram_we <= 1'b1;
        end else begin
          state <= ST_RD_I;
        end
      end else if (busy && abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          ST_FILL: begin
            if (i == LAST_IDX) begin
              i        <= '0;
              ram_addr <= '0;
              state    <= ST_RD_I;
            end else begin
              i         <= i_inc;
              ram_addr  <= i_inc;
              ram_wdata <= i_inc;
              ram_we    <= 1'b1;
            end
          end
          ST_RD_I: state <= ST_WAIT_I;
          ST_WAIT_I: begin
            if (wait_expired) begin
              si       <= ram_rdata;
              j        <= j_next;
              ram_addr <= j_next;
              state    <= ST_RD_J;
            end
          end
          ST_RD_J: state <= ST_WAIT_J;
          ST_WAIT_J: begin
            if (wait_expired) begin
              ram_addr  <= i;
              ram_wdata <= ram_rdata;
              ram_we    <= 1'b1;
              state     <= ST_WR_I;
            end
          end
          ST_WR_I: begin
            ram_addr  <= j;
            ram_wdata <= si;
            ram_we    <= 1'b1;
            state     <= ST_WR_J;
          end
          ST_WR_J: begin
            if (i == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_FIN;
            end else begin
              i        <= i_inc;
              ram_addr <= i_inc;
              k        <= (k == k_last) ? '0 : k + KW'(1);
              state    <= ST_RD_I;
            end
          end
          ST_FIN:  state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
